// File: rtl/if_id_pkg.sv
// Shared widths, NOP encoding and beat layout for the IF/ID pipeline register.
package if_id_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int ADDR_W_DEF  = 32;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc_adder;
  } if_id_beat_t;

endpackage

// File: rtl/if_id_skid_slot.sv
// One-entry valid+data holding register; clear beats load, load beats unload.
module if_id_skid_slot #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake, flush bubble and stall counter.
// Optional skid entry (registered In_Ready) enabled by defining IF_ID_PIPE_SKID_EN.
module if_id_pipe_reg
  import if_id_pkg::*;
#(
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter int                 ADDR_W    = ADDR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}},
  parameter int                 CNT_W     = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [INSTR_W-1:0] In_Instruction,
  input  logic [ADDR_W-1:0]  In_PCAdder,
  input  logic               Flush,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [INSTR_W-1:0] Out_Instruction,
  output logic [ADDR_W-1:0]  Out_PCAdder,
  output logic [ADDR_W-1:0]  Out_PrevPCAdder,
  output logic [CNT_W-1:0]   Stall_Count
);

  // Handshake: a beat moves when valid and ready are both high at a rising edge;
  // valid never depends on ready, and a presented beat is held until taken.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               main_valid;
  logic [INSTR_W-1:0] main_instr;
  logic [ADDR_W-1:0]  main_pc;
  logic [ADDR_W-1:0]  prev_pc;
  logic [CNT_W-1:0]   stall_cnt;

  logic               accept;
  logic               release_beat;
  logic               main_free;
  logic               load_main;
  logic [INSTR_W-1:0] load_instr;
  logic [ADDR_W-1:0]  load_pc;

  assign accept       = In_Valid & In_Ready;
  assign release_beat = main_valid & Out_Ready;
  assign main_free    = ~main_valid | release_beat;

`ifdef IF_ID_PIPE_SKID_EN
  localparam int BEAT_W = INSTR_W + ADDR_W;

  logic              skid_valid;
  logic [BEAT_W-1:0] skid_data;
  logic              skid_load;
  logic              skid_unload;

  // In_Ready only looks at the skid flop, so Out_Ready never reaches fetch.
  assign In_Ready    = ~skid_valid;
  assign skid_load   = accept & ~main_free;
  assign skid_unload = skid_valid & main_free;

  always_comb begin
    load_main  = 1'b0;
    load_instr = In_Instruction;
    load_pc    = In_PCAdder;
    if (skid_unload) begin
      load_main               = 1'b1;
      {load_instr, load_pc}   = skid_data;
    end else if (accept & main_free) begin
      load_main = 1'b1;
    end
  end

  if_id_skid_slot #(
    .W(BEAT_W)
  ) u_skid (
    .clk       (Clock),
    .rst       (Reset),
    .clear     (Flush),
    .load      (skid_load),
    .unload    (skid_unload),
    .load_data ({In_Instruction, In_PCAdder}),
    .valid     (skid_valid),
    .data      (skid_data)
  );
`else
  assign In_Ready = ~main_valid | Out_Ready;

  always_comb begin
    load_main  = accept;
    load_instr = In_Instruction;
    load_pc    = In_PCAdder;
  end
`endif

  // PC fields deliberately survive flush and drain; only a new load moves them.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      main_valid <= 1'b0;
      main_instr <= NOP_INSTR;
      main_pc    <= '0;
      prev_pc    <= '0;
    end else if (Flush) begin
      main_valid <= 1'b0;
      main_instr <= NOP_INSTR;
    end else if (load_main) begin
      main_valid <= 1'b1;
      main_instr <= load_instr;
      prev_pc    <= main_pc;
      main_pc    <= load_pc;
    end else if (release_beat) begin
      main_valid <= 1'b0;
      main_instr <= NOP_INSTR;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !Out_Ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign Out_Valid       = main_valid;
  assign Out_Instruction = main_instr;
  assign Out_PCAdder     = main_pc;
  assign Out_PrevPCAdder = prev_pc;
  assign Stall_Count     = stall_cnt;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg (either build of IF_ID_PIPE_SKID_EN), CNT_W=4.
module tb_if_id_pipe_reg;
  import if_id_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef IF_ID_PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic             Clock;
  logic             Reset;
  logic             In_Valid;
  logic             In_Ready;
  logic [31:0]      In_Instruction;
  logic [31:0]      In_PCAdder;
  logic             Flush;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [31:0]      Out_Instruction;
  logic [31:0]      Out_PCAdder;
  logic [31:0]      Out_PrevPCAdder;
  logic [CNT_W-1:0] Stall_Count;

  if_id_pipe_reg #(
    .CNT_W(CNT_W)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .In_Valid       (In_Valid),
    .In_Ready       (In_Ready),
    .In_Instruction (In_Instruction),
    .In_PCAdder     (In_PCAdder),
    .Flush          (Flush),
    .Out_Valid      (Out_Valid),
    .Out_Ready      (Out_Ready),
    .Out_Instruction(Out_Instruction),
    .Out_PCAdder    (Out_PCAdder),
    .Out_PrevPCAdder(Out_PrevPCAdder),
    .Stall_Count    (Stall_Count)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // scoreboard state
  if_id_beat_t exp_q[$];
  int          exp_id[$];
  if_id_beat_t stim_q[$];
  int          next_id = 0;
  int          head_id = -1;
  logic [31:0] m_pc   = '0;
  logic [31:0] m_prev = '0;
  int          m_stall = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_beat(input logic [31:0] pc, input logic [31:0] instr);
    if_id_beat_t b;
    b.instr    = instr;
    b.pc_adder = pc;
    stim_q.push_back(b);
  endtask

  // One clock: drive, check outputs against the model, take the edge, update the model.
  task automatic step();
    logic        exp_valid;
    logic        exp_rdy;
    logic [31:0] exp_instr;
    logic        acc;
    logic        rel;
    if_id_beat_t nb;
    In_Valid = (stim_q.size() > 0);
    if (stim_q.size() > 0) begin
      In_Instruction = stim_q[0].instr;
      In_PCAdder     = stim_q[0].pc_adder;
    end
    #1;
    exp_valid = (exp_q.size() > 0);
    exp_rdy   = (CAP == 2) ? (exp_q.size() < 2) : (exp_q.size() == 0 || Out_Ready);
    exp_instr = exp_valid ? exp_q[0].instr : 32'h0;
    check("out_valid", 64'(Out_Valid), 64'(exp_valid));
    check("in_ready", 64'(In_Ready), 64'(exp_rdy));
    check("out_instr", 64'(Out_Instruction), 64'(exp_instr));
    check("out_pc", 64'(Out_PCAdder), 64'(exp_valid ? exp_q[0].pc_adder : m_pc));
    check("prev_pc", 64'(Out_PrevPCAdder), 64'(m_prev));
    check("stall_cnt", 64'(Stall_Count), 64'(m_stall));
    acc = In_Valid & exp_rdy;
    rel = exp_valid & Out_Ready;
    @(posedge Clock);
    if (Reset) begin
      exp_q.delete();
      exp_id.delete();
      head_id = -1;
      m_pc    = '0;
      m_prev  = '0;
      m_stall = 0;
      stim_q.delete();
    end else begin
      if (exp_valid && !Out_Ready && m_stall < CNT_MAX) m_stall++;
      if (Flush) begin
        exp_q.delete();
        exp_id.delete();
        stim_q.delete();
      end else begin
        if (rel) begin
          void'(exp_q.pop_front());
          void'(exp_id.pop_front());
        end
        if (acc) begin
          nb = stim_q.pop_front();
          exp_q.push_back(nb);
          exp_id.push_back(next_id);
          next_id++;
        end
      end
      if (exp_q.size() > 0 && exp_id[0] != head_id) begin
        m_prev  = m_pc;
        m_pc    = exp_q[0].pc_adder;
        head_id = exp_id[0];
      end
    end
    @(negedge Clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset          = 1'b1;
    Flush          = 1'b0;
    Out_Ready      = 1'b0;
    In_Valid       = 1'b1;
    In_Instruction = 32'hDEAD_BEEF;
    In_PCAdder     = 32'h100;
    @(negedge Clock);
    @(posedge Clock);
    @(negedge Clock);

    // reset held a second cycle with a beat offered
    push_beat(32'h100, 32'hDEAD_BEEF);
    do_reset();

    // streaming
    Out_Ready = 1'b1;
    push_beat(32'h4, 32'h2008_0001);
    push_beat(32'h8, 32'h2008_0002);
    push_beat(32'hC, 32'h2008_0003);
    run(5);

    // backpressure with 0x8 held in main
    do_reset();
    push_beat(32'h4, 32'h2008_0001);
    push_beat(32'h8, 32'h2008_0002);
    push_beat(32'hC, 32'h2008_0003);
    Out_Ready = 1'b1;
    run(2);
    Out_Ready = 1'b0;
    run(5);
    check("stall_after_5", 64'(Stall_Count), 64'd5);
    Out_Ready = 1'b1;
    run(4);

    // flush with main (and skid) full and a wrong-path beat offered
    push_beat(32'h20, 32'h2008_0020);
    push_beat(32'h24, 32'h2008_0024);
    push_beat(32'h10, 32'h2008_0010);
    Out_Ready = 1'b0;
    run(3);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    Out_Ready = 1'b1;
    run(3);

    // flush in the same cycle a beat is accepted into an empty register
    push_beat(32'h30, 32'h2008_0030);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    run(2);

    // counter saturation then reset mid-stall
    push_beat(32'h40, 32'h2008_0040);
    push_beat(32'h44, 32'h2008_0044);
    Out_Ready = 1'b0;
    run(20);
    check("stall_sat", 64'(Stall_Count), 64'(CNT_MAX));
    do_reset();
    Out_Ready = 1'b1;
    run(3);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (stim_q.size() < 3 && $urandom_range(0, 2) != 0)
        push_beat($urandom(), $urandom());
      Out_Ready = ($urandom_range(0, 3) != 0);
      Flush     = ($urandom_range(0, 24) == 0);
      Reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    Flush = 1'b0;
    Reset = 1'b0;
    Out_Ready = 1'b1;
    run(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
